// File: rtl/read_stage_bypass.sv
// Operand-read stage: resolves register operands through bypass channels and
// issues memory loads with a wait-state handshake, bounded timeout and CX mode.
//
// state | meaning
// IDLE  | accepting; ALU ops and zero-wait loads complete here
// WAIT  | load requested, waiting for data or timeout
// HOLD  | load result (data or fault) buffered, waiting for downstream
module read_stage_bypass #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int FWD_PORTS  = 2,
    parameter int MAX_WAIT   = 15,
    parameter int ZERO_REG   = 1,
    localparam int RW        = $clog2(REG_COUNT)
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [REG_COUNT*DATA_WIDTH-1:0] registers,
    input  logic                            in_valid,
    output logic                            in_hold,
    input  logic [DATA_WIDTH-1:0]           in_pc,
    input  logic [RW-1:0]                   in_left_reg,
    input  logic [RW-1:0]                   in_right_reg,
    input  logic [RW-1:0]                   in_addr_reg,
    input  logic [RW-1:0]                   in_dest_reg,
    input  logic                            in_is_reading_memory,
    input  logic                            in_is_writing_memory,
    input  logic [DATA_WIDTH-1:0]           in_adjust,
    input  logic [FWD_PORTS-1:0]            fwd_valid,
    input  logic [FWD_PORTS*RW-1:0]         fwd_reg,
    input  logic [FWD_PORTS*DATA_WIDTH-1:0] fwd_value,
    output logic                            mem_address_enable,
    output logic [DATA_WIDTH-1:0]           mem_address,
    input  logic                            mem_data_valid,
    input  logic [DATA_WIDTH-1:0]           mem_data,
    output logic                            out_valid,
    input  logic                            out_hold,
    output logic [DATA_WIDTH-1:0]           out_pc,
    output logic [DATA_WIDTH-1:0]           out_left_value,
    output logic [DATA_WIDTH-1:0]           out_right_value,
    output logic [DATA_WIDTH-1:0]           out_adjust,
    output logic [RW-1:0]                   out_dest_reg,
    output logic                            out_is_writing_memory,
    output logic                            out_fault
);

    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  fault_pend_q, fault_pend_d;

    logic                  out_valid_q, out_fault_q, out_wr_q;
    logic [DATA_WIDTH-1:0] out_pc_q, out_left_q, out_right_q, out_adjust_q;
    logic [RW-1:0]         out_dest_q;

    logic [DATA_WIDTH-1:0] left_res, right_res, addr_res, addr_calc;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_fault, complete, mem_en, timeout;
    logic [DATA_WIDTH-1:0] mem_addr;

    // Lowest-numbered matching channel wins; register 0 is never bypassed.
    function automatic logic [DATA_WIDTH-1:0] resolve(
        input logic [RW-1:0]                   r,
        input logic [REG_COUNT*DATA_WIDTH-1:0] rf,
        input logic [FWD_PORTS-1:0]            fv,
        input logic [FWD_PORTS*RW-1:0]         fr,
        input logic [FWD_PORTS*DATA_WIDTH-1:0] fd
    );
        logic [DATA_WIDTH-1:0] v;
        v = rf[int'(r)*DATA_WIDTH +: DATA_WIDTH];
        for (int j = FWD_PORTS - 1; j >= 0; j--) begin
            if (fv[j] && (fr[j*RW +: RW] == r)) v = fd[j*DATA_WIDTH +: DATA_WIDTH];
        end
        if ((ZERO_REG != 0) && (r == '0)) v = '0;
        return v;
    endfunction

    always_comb begin
        left_res  = resolve(in_left_reg,  registers, fwd_valid, fwd_reg, fwd_value);
        right_res = resolve(in_right_reg, registers, fwd_valid, fwd_reg, fwd_value);
        addr_res  = resolve(in_addr_reg,  registers, fwd_valid, fwd_reg, fwd_value);
        addr_calc = addr_res + in_adjust;
        timeout   = (MAX_WAIT != 0) && (cnt_q == CW'(MAX_WAIT));
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        buf_d        = buf_q;
        fault_pend_d = fault_pend_q;
        complete     = 1'b0;
        load_data    = '0;
        load_fault   = 1'b0;
        mem_en       = 1'b0;
        mem_addr     = addr_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_is_reading_memory) begin
                    mem_en   = 1'b1;
                    mem_addr = addr_calc;
                    addr_d   = addr_calc;
                    if (mem_data_valid) begin
                        if (!out_hold) begin
                            complete  = 1'b1;
                            load_data = mem_data;
                        end else begin
                            state_d      = S_HOLD;
                            buf_d        = mem_data;
                            fault_pend_d = 1'b0;
                        end
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(1);
                    end
                end else if (in_valid && !out_hold) begin
                    complete = 1'b1;
                end
            end
            S_WAIT: begin
                mem_en = 1'b1;
                cnt_d  = cnt_q + CW'(1);
                if (mem_data_valid) begin
                    if (!out_hold) begin
                        complete  = 1'b1;
                        load_data = mem_data;
                        state_d   = S_IDLE;
                    end else begin
                        state_d      = S_HOLD;
                        buf_d        = mem_data;
                        fault_pend_d = 1'b0;
                    end
                end else if (timeout) begin
                    if (!out_hold) begin
                        complete   = 1'b1;
                        load_fault = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d      = S_HOLD;
                        fault_pend_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (!out_hold) begin
                    complete   = 1'b1;
                    load_data  = buf_q;
                    load_fault = fault_pend_q;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            buf_q        <= '0;
            fault_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            buf_q        <= buf_d;
            fault_pend_q <= fault_pend_d;
        end
    end

    // Operands are sampled at completion so bypasses arriving late are honoured.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_fault_q  <= 1'b0;
            out_wr_q     <= 1'b0;
            out_pc_q     <= '0;
            out_left_q   <= '0;
            out_right_q  <= '0;
            out_adjust_q <= '0;
            out_dest_q   <= '0;
        end else if (!out_hold) begin
            out_valid_q <= complete;
            if (complete) begin
                out_pc_q   <= in_pc;
                out_left_q <= left_res;
                out_dest_q <= in_dest_reg;
                out_wr_q   <= in_is_writing_memory;
                if (in_is_reading_memory) begin
                    out_right_q  <= load_fault ? '0 : load_data;
                    out_adjust_q <= in_is_writing_memory ? right_res : in_adjust;
                    out_fault_q  <= load_fault;
                end else begin
                    out_right_q  <= right_res;
                    out_adjust_q <= in_adjust;
                    out_fault_q  <= 1'b0;
                end
            end
        end
    end

    assign in_hold               = in_valid && !complete;
    assign mem_address_enable    = mem_en;
    assign mem_address           = mem_addr;
    assign out_valid             = out_valid_q;
    assign out_fault             = out_fault_q;
    assign out_is_writing_memory = out_wr_q;
    assign out_pc                = out_pc_q;
    assign out_left_value        = out_left_q;
    assign out_right_value       = out_right_q;
    assign out_adjust            = out_adjust_q;
    assign out_dest_reg          = out_dest_q;

endmodule

// File: tb/tb_read_stage_bypass.sv
// Directed bench for read_stage_bypass: transaction-level model predicts each
// instruction's result and cycle timing; a monitor checks every new output.
module tb_read_stage_bypass;

    localparam int DW = 32;
    localparam int RC = 32;
    localparam int FP = 2;
    localparam int MW = 4;
    localparam int RW = 5;

    logic               clock = 1'b0;
    logic               reset_n;
    logic [RC*DW-1:0]   registers;
    logic               in_valid;
    logic               in_hold;
    logic [DW-1:0]      in_pc;
    logic [RW-1:0]      in_left_reg, in_right_reg, in_addr_reg, in_dest_reg;
    logic               in_is_reading_memory, in_is_writing_memory;
    logic [DW-1:0]      in_adjust;
    logic [FP-1:0]      fwd_valid;
    logic [FP*RW-1:0]   fwd_reg;
    logic [FP*DW-1:0]   fwd_value;
    logic               mem_address_enable;
    logic [DW-1:0]      mem_address;
    logic               mem_data_valid;
    logic [DW-1:0]      mem_data;
    logic               out_valid;
    logic               out_hold;
    logic [DW-1:0]      out_pc, out_left_value, out_right_value, out_adjust;
    logic [RW-1:0]      out_dest_reg;
    logic               out_is_writing_memory, out_fault;

    read_stage_bypass #(
        .DATA_WIDTH(DW), .REG_COUNT(RC), .FWD_PORTS(FP), .MAX_WAIT(MW), .ZERO_REG(1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .registers(registers),
        .in_valid(in_valid), .in_hold(in_hold), .in_pc(in_pc),
        .in_left_reg(in_left_reg), .in_right_reg(in_right_reg),
        .in_addr_reg(in_addr_reg), .in_dest_reg(in_dest_reg),
        .in_is_reading_memory(in_is_reading_memory),
        .in_is_writing_memory(in_is_writing_memory),
        .in_adjust(in_adjust), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
        .fwd_value(fwd_value), .mem_address_enable(mem_address_enable),
        .mem_address(mem_address), .mem_data_valid(mem_data_valid),
        .mem_data(mem_data), .out_valid(out_valid), .out_hold(out_hold),
        .out_pc(out_pc), .out_left_value(out_left_value),
        .out_right_value(out_right_value), .out_adjust(out_adjust),
        .out_dest_reg(out_dest_reg), .out_is_writing_memory(out_is_writing_memory),
        .out_fault(out_fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] pc, left, right, adj;
        logic [RW-1:0] dest;
        logic          wr, fault, chk_left;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic hold_prev = 1'b1;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mres(input logic [RW-1:0] r);
        if (r == 0) return '0;
        for (int j = 0; j < FP; j++)
            if (fwd_valid[j] && fwd_reg[j*RW +: RW] == r) return fwd_value[j*DW +: DW];
        return registers[int'(r)*DW +: DW];
    endfunction

    task automatic set_reg(input int i, input logic [DW-1:0] v);
        registers[i*DW +: DW] = v;
    endtask

    task automatic set_fwd(input int j, input logic v, input logic [RW-1:0] r, input logic [DW-1:0] d);
        fwd_valid[j]          = v;
        fwd_reg[j*RW +: RW]   = r;
        fwd_value[j*DW +: DW] = d;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the completion edge.
    // data_at: cycle index at which mem_data_valid pulses (-1: never).
    // Downstream holds during cycles [hs, hs+hl).
    task automatic run_instr(
        input logic [DW-1:0] pc, input logic [RW-1:0] l, r, a, d,
        input logic rd, wr, input logic [DW-1:0] adj,
        input int data_at, input logic [DW-1:0] data, input int hs, input int hl);
        exp_t e;
        int ready, compl;
        logic flt;
        logic [DW-1:0] exp_addr;
        in_valid = 1'b1; in_pc = pc; in_left_reg = l; in_right_reg = r;
        in_addr_reg = a; in_dest_reg = d; in_is_reading_memory = rd;
        in_is_writing_memory = wr; in_adjust = adj; mem_data = data;
        exp_addr = mres(a) + adj;
        flt = 1'b0;
        if (!rd) ready = 0;
        else if (data_at >= 0 && data_at <= MW) ready = data_at;
        else begin ready = MW; flt = 1'b1; end
        compl = ready;
        while (compl >= hs && compl < hs + hl) compl++;
        e.pc = pc; e.left = mres(l); e.dest = d; e.wr = wr; e.fault = flt;
        e.chk_left = !rd;
        e.right = rd ? (flt ? '0 : data) : mres(r);
        e.adj   = (rd && wr) ? mres(r) : adj;
        for (int cyc = 0; cyc <= compl; cyc++) begin
            mem_data_valid = (cyc == data_at);
            out_hold       = (cyc >= hs && cyc < hs + hl);
            @(negedge clock);
            chk("in_hold", DW'(in_hold), DW'(cyc < compl));
            chk("mem_en", DW'(mem_address_enable), DW'(rd && cyc <= ready));
            if (rd && cyc <= ready) chk("mem_address", mem_address, exp_addr);
            if (cyc == compl) exp_q.push_back(e);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0; mem_data_valid = 1'b0; out_hold = 1'b0;
    endtask

    // Monitor: a new result appears on any cycle after a non-held edge with out_valid set.
    always @(negedge clock) begin
        if (reset_n && out_valid && !hold_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", DW'(out_valid), '0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_pc", out_pc, e.pc);
                chk("mon_right", out_right_value, e.right);
                chk("mon_adjust", out_adjust, e.adj);
                chk("mon_dest", DW'(out_dest_reg), DW'(e.dest));
                chk("mon_wr", DW'(out_is_writing_memory), DW'(e.wr));
                chk("mon_fault", DW'(out_fault), DW'(e.fault));
                if (e.chk_left) chk("mon_left", out_left_value, e.left);
            end
        end
        hold_prev = out_hold;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; registers = '0; in_valid = 1'b0; in_pc = '0;
        in_left_reg = '0; in_right_reg = '0; in_addr_reg = '0; in_dest_reg = '0;
        in_is_reading_memory = 1'b0; in_is_writing_memory = 1'b0; in_adjust = '0;
        fwd_valid = '0; fwd_reg = '0; fwd_value = '0; mem_data_valid = 1'b0;
        mem_data = '0; out_hold = 1'b0;
        for (int i = 0; i < RC; i++) set_reg(i, 32'h1000 + i);
        set_reg(3, 32'h10); set_reg(4, 32'h20); set_reg(5, 32'h100); set_reg(2, 32'h7);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_fault", DW'(out_fault), '0);
        chk("rst_mem_en", DW'(mem_address_enable), '0);
        chk("rst_in_hold", DW'(in_hold), '0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // ALU passthrough
        run_instr(32'h1000, 3, 4, 0, 7, 0, 0, 32'h11, -1, 0, 0, 0);
        chk("alu_valid", DW'(out_valid), 1);
        chk("alu_left", out_left_value, 32'h10);
        chk("alu_right", out_right_value, 32'h20);

        // Bypass priority
        set_fwd(0, 1, 3, 32'hAA); set_fwd(1, 1, 3, 32'hBB);
        run_instr(32'h1004, 3, 4, 0, 8, 0, 0, 0, -1, 0, 0, 0);
        chk("byp_left", out_left_value, 32'hAA);

        // Register 0 is never bypassed
        set_fwd(0, 1, 0, 32'h55); set_fwd(1, 0, 0, 0);
        run_instr(32'h1008, 0, 3, 0, 9, 0, 0, 0, -1, 0, 0, 0);
        chk("zero_left", out_left_value, 32'h0);
        chk("zero_right", out_right_value, 32'h10);
        fwd_valid = '0;

        // Load with data after three wait cycles
        run_instr(32'h100C, 0, 0, 5, 10, 1, 0, 32'h4, 3, 32'hDEAD, 0, 0);
        chk("ld_right", out_right_value, 32'hDEAD);
        chk("ld_fault", DW'(out_fault), 0);
        chk("ld_adjust", out_adjust, 32'h4);

        // Timeout, then next instruction is accepted
        run_instr(32'h1010, 0, 0, 5, 11, 1, 0, 32'h8, -1, 32'hBAD, 0, 0);
        chk("to_fault", DW'(out_fault), 1);
        chk("to_right", out_right_value, 32'h0);
        run_instr(32'h1014, 4, 3, 0, 12, 0, 0, 0, -1, 0, 0, 0);

        // Data in the timeout cycle wins
        run_instr(32'h1018, 0, 0, 5, 13, 1, 0, 0, MW, 32'h1234, 0, 0);
        chk("late_fault", DW'(out_fault), 0);
        chk("late_right", out_right_value, 32'h1234);

        // CX under backpressure
        run_instr(32'h101C, 0, 2, 5, 14, 1, 1, 0, 1, 32'h9, 1, 3);
        chk("cx_right", out_right_value, 32'h9);
        chk("cx_adjust", out_adjust, 32'h7);
        chk("cx_wr", DW'(out_is_writing_memory), 1);

        // Zero-wait load, zero-wait load into HOLD, timeout into HOLD, held ALU
        run_instr(32'h1020, 0, 0, 4, 15, 1, 0, 32'h3, 0, 32'hCAFE, 0, 0);
        run_instr(32'h1024, 0, 0, 3, 16, 1, 0, 32'h1, 0, 32'hF00D, 0, 2);
        run_instr(32'h1028, 0, 0, 3, 17, 1, 0, 32'h1, -1, 32'h77, 3, 4);
        chk("to_hold_fault", DW'(out_fault), 1);
        run_instr(32'h102C, 6, 7, 0, 18, 0, 1, 32'h5, -1, 0, 0, 2);

        // Bypassed address register with address wrap-around
        set_fwd(0, 1, 5, 32'hFFFF_FFF0);
        run_instr(32'h1030, 0, 5, 5, 19, 1, 1, 32'h14, 2, 32'h42, 0, 0);
        chk("byp_ld_adjust", out_adjust, 32'hFFFF_FFF0);
        fwd_valid = '0;

        // Reset during WAIT abandons the instruction
        out_hold = 1'b1;
        in_valid = 1'b1; in_is_reading_memory = 1'b1; in_is_writing_memory = 1'b0;
        in_addr_reg = 5; in_adjust = 0; in_pc = 32'h2000;
        repeat (2) begin @(posedge clock); #1; end
        chk("pre_rst_valid", DW'(out_valid), 1);
        chk("pre_rst_mem_en", DW'(mem_address_enable), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", DW'(out_valid), 0);
        in_valid = 1'b0;
        #1;
        chk("mid_rst_mem_en", DW'(mem_address_enable), 0);
        @(posedge clock); #1;
        reset_n = 1'b1; out_hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_data_valid = (i == 1);
            @(negedge clock);
            chk("post_rst_valid", DW'(out_valid), 0);
        end
        mem_data_valid = 1'b0;
        @(posedge clock); #1;
        run_instr(32'h2004, 3, 4, 0, 20, 0, 0, 32'h9, -1, 0, 0, 0);
        chk("post_rst_alu_left", out_left_value, 32'h10);
        repeat (3) @(posedge clock);
        chk("queue_drained", DW'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/read_stage_bypass.md
Name: read_stage_bypass

Overview:
- Parametrised operand-read stage between decode and execute.
- Resolves left/right/address operands from the register file, with a configurable number of bypass channels from later stages.
- Issues memory loads with a wait-state handshake and a bounded timeout.
- Exchange (CX) mode: a combined read and write returns the memory word as the right value and the old register value as the adjustment.

Parameters:
- DATA_WIDTH, 32, width of registers, addresses and data.
- REG_COUNT, 32, number of architectural registers; RW = $clog2(REG_COUNT).
- FWD_PORTS, 2, number of bypass channels; channel 0 has highest priority (youngest).
- MAX_WAIT, 15, wait cycles before a load faults; 0 disables the timeout.
- ZERO_REG, 1, when 1, register 0 always reads 0 and is never bypassed.

Ports:
- clock  in  1  stage clock.
- reset_n  in  1  asynchronous active-low reset.
- registers  in  REG_COUNT*DATA_WIDTH  register file snapshot; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  1  upstream instruction valid.
- in_hold  out  1  stall to upstream.
- in_pc  in  DATA_WIDTH  instruction pc.
- in_left_reg, in_right_reg, in_addr_reg, in_dest_reg  in  RW each  register indices.
- in_is_reading_memory, in_is_writing_memory  in  1 each  memory operation flags.
- in_adjust  in  DATA_WIDTH  address offset / adjustment value.
- fwd_valid  in  FWD_PORTS  bypass channel valid.
- fwd_reg  in  FWD_PORTS*RW  bypass destination register index.
- fwd_value  in  FWD_PORTS*DATA_WIDTH  bypass value.
- mem_address_enable  out  1  load request.
- mem_address  out  DATA_WIDTH  load address.
- mem_data_valid  in  1  load data returned.
- mem_data  in  DATA_WIDTH  load data.
- out_valid  out  1  downstream instruction valid.
- out_hold  in  1  downstream stall.
- out_pc, out_left_value, out_right_value, out_adjust  out  DATA_WIDTH each  registered results.
- out_dest_reg  out  RW  registered destination register index.
- out_is_writing_memory, out_fault  out  1 each  registered flags.

Behaviour:
- Operand resolution (combinational, per index r):
  - if ZERO_REG and r==0, result is 0;
  - else the lowest j with fwd_valid[j] && fwd_reg[j]==r supplies fwd_value[j];
  - else registers[r].
- Operands are resolved in the cycle the output register loads, so late bypasses are honoured.
- FSM states: IDLE, WAIT, HOLD. Reset: state IDLE, wait counter 0, out_valid 0, out_fault 0; other outputs don't-care.
- IDLE, non-load instruction (in_valid && !in_is_reading_memory):
  - completes when !out_hold;
  - out_left/out_right = resolved operands, out_adjust = in_adjust.
- IDLE, load instruction (in_valid && in_is_reading_memory):
  - mem_address_enable = 1; mem_address = resolved(in_addr_reg) + in_adjust, modulo 2^DATA_WIDTH.
  - The address is latched into an internal register.
  - If mem_data_valid in the same cycle and !out_hold: complete (zero-wait).
  - If mem_data_valid and out_hold: buffer the data, go to HOLD.
  - Else go to WAIT with counter = 1.
- WAIT:
  - mem_address_enable = 1, mem_address = latched address (stable while waiting).
  - The counter increments each cycle.
  - mem_data_valid: complete if !out_hold, else buffer the data and go to HOLD.
  - Timeout when MAX_WAIT != 0 and counter == MAX_WAIT without data: complete with out_fault = 1 and out_right_value = 0. If out_hold is asserted, go to HOLD with fault pending.
  - Data arriving in the timeout cycle wins; no fault.
- HOLD: mem_address_enable = 0; completes when !out_hold.
- Load completion values:
  - out_right_value = load data.
  - CX (reading && writing): out_adjust = resolved(in_right_reg); otherwise out_adjust = in_adjust.
- Completion: the output register loads all out_* fields, out_valid <= 1, state goes to IDLE.
- When out_hold is low and nothing completes, out_valid <= 0. When out_hold is high, all outputs hold.
- in_hold = in_valid && !completing_this_cycle. The upstream instruction fields must stay stable while in_hold is high.
- mem_data_valid outside IDLE-load or WAIT is ignored.
- in_valid low: no request, nothing completes.
- Asserting reset during WAIT or HOLD abandons the instruction; no output is produced.

Test Plan:
- ALU passthrough: regs[3]=0x10, regs[4]=0x20; left=3, right=4, out_hold=0 -> next cycle out_valid=1, left=0x10, right=0x20, in_hold never asserted.
- Bypass priority: fwd0=(3,0xAA), fwd1=(3,0xBB), left=3 -> left=0xAA. With ZERO_REG=1, left=0 and fwd0=(0,0x55) -> left=0.
- Load, 3 wait cycles: regs[5]=0x100, in_adjust=4 -> mem_address=0x104 held for 4 cycles, in_hold high for 3 cycles, then data 0xDEAD -> right=0xDEAD, fault=0.
- Timeout: MAX_WAIT=4, no data -> out_fault=1, right=0, FSM returns to IDLE, next instruction accepted. Data arriving in cycle 4 -> no fault.
- CX under backpressure: regs[2]=0x7, data 0x9 arrives while out_hold=1 -> in HOLD, mem_address_enable=0; after release, right=0x9, adjust=0x7, is_writing=1.
- Reset asserted mid-WAIT -> out_valid=0 immediately, mem_address_enable=0 once in_valid drops, no stale completion afterwards.
